// File: rtl/vid_timing_rx.sv
// vid_timing_rx: measures horizontal/vertical timing of a raster stream and declares lock.
// Optional grey-ramp pixel checker enabled by defining VID_TIMING_RX_PATTERN_CHECK_EN.

module vid_timing_rx #(
  parameter int PW       = 8,
  parameter int H_BITS   = 12,
  parameter int V_BITS   = 12,
  parameter int ERR_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                hs,
  input  logic                vs,
  input  logic                vld,
  input  logic [3*PW-1:0]     rgb,
  output logic [H_BITS-1:0]   h_total,
  output logic [H_BITS-1:0]   hs_width,
  output logic [H_BITS-1:0]   h_active,
  output logic [V_BITS-1:0]   v_total,
  output logic [V_BITS-1:0]   vs_width,
  output logic [V_BITS-1:0]   v_active,
  output logic                frame_done,
  output logic                locked,
  output logic                pixel_err,
  output logic [ERR_BITS-1:0] err_cnt
);

  typedef enum logic [1:0] {SEARCH, SYNC, MEASURE, LOCKED} state_t;

  typedef struct packed {
    logic [H_BITS-1:0] h_total;
    logic [H_BITS-1:0] hs_width;
    logic [H_BITS-1:0] h_active;
    logic [V_BITS-1:0] v_total;
    logic [V_BITS-1:0] vs_width;
    logic [V_BITS-1:0] v_active;
  } meas_t;

  function automatic logic [H_BITS-1:0] hinc(input logic [H_BITS-1:0] v);
    return (&v) ? v : v + H_BITS'(1);
  endfunction

  function automatic logic [V_BITS-1:0] vinc(input logic [V_BITS-1:0] v);
    return (&v) ? v : v + V_BITS'(1);
  endfunction

  // ---------------- input stage ----------------
  logic s1_hs_q, s1_vs_q, s1_vld_q;
  logic s2_hs_q, s2_vs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_hs_q  <= 1'b0;
      s1_vs_q  <= 1'b0;
      s1_vld_q <= 1'b0;
      s2_hs_q  <= 1'b0;
      s2_vs_q  <= 1'b0;
    end else begin
      s1_hs_q  <= hs;
      s1_vs_q  <= vs;
      s1_vld_q <= vld;
      s2_hs_q  <= s1_hs_q;
      s2_vs_q  <= s1_vs_q;
    end
  end

  logic line_start, frame_start, line_evt;
  assign line_start  = s1_hs_q & ~s2_hs_q;
  assign frame_start = s1_vs_q & ~s2_vs_q;
  // A stray frame start that misses the hs edge still closes the current line.
  assign line_evt    = line_start | frame_start;

  // ---------------- line counters ----------------
  logic [H_BITS-1:0] hcnt_q, hcnt_d;
  logic [H_BITS-1:0] hs_cnt_q, hs_cnt_d;
  logic [H_BITS-1:0] act_cnt_q, act_cnt_d;
  logic [H_BITS-1:0] last_h_total_q, last_h_total_d;
  logic [H_BITS-1:0] last_hs_width_q, last_hs_width_d;

  always_comb begin
    hcnt_d          = hinc(hcnt_q);
    hs_cnt_d        = s1_hs_q  ? hinc(hs_cnt_q)  : hs_cnt_q;
    act_cnt_d       = s1_vld_q ? hinc(act_cnt_q) : act_cnt_q;
    last_h_total_d  = last_h_total_q;
    last_hs_width_d = last_hs_width_q;
    if (line_evt) begin
      last_h_total_d  = hcnt_q;
      last_hs_width_d = hs_cnt_q;
      hcnt_d          = H_BITS'(1);
      hs_cnt_d        = H_BITS'(s1_hs_q);
      act_cnt_d       = H_BITS'(s1_vld_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q          <= '0;
      hs_cnt_q        <= '0;
      act_cnt_q       <= '0;
      last_h_total_q  <= '0;
      last_hs_width_q <= '0;
    end else begin
      hcnt_q          <= hcnt_d;
      hs_cnt_q        <= hs_cnt_d;
      act_cnt_q       <= act_cnt_d;
      last_h_total_q  <= last_h_total_d;
      last_hs_width_q <= last_hs_width_d;
    end
  end

  // ---------------- frame counters ----------------
  state_t            state_q;
  logic              fs_q;
  logic              frame_clr;
  logic [V_BITS-1:0] lcnt_q, lcnt_d;
  logic [V_BITS-1:0] vs_cnt_q, vs_cnt_d;
  logic [V_BITS-1:0] vact_cnt_q, vact_cnt_d;
  logic [H_BITS-1:0] max_act_q, max_act_d;

  // fs_q lags the frame start by one clock so the latch sees the closing line's updates.
  assign frame_clr = fs_q | (state_q == SEARCH);

  always_comb begin
    lcnt_d     = lcnt_q;
    vs_cnt_d   = vs_cnt_q;
    vact_cnt_d = vact_cnt_q;
    max_act_d  = max_act_q;
    if (frame_clr) begin
      lcnt_d     = '0;
      vs_cnt_d   = '0;
      vact_cnt_d = '0;
      max_act_d  = '0;
    end else if (line_evt) begin
      lcnt_d = vinc(lcnt_q);
      if (s1_vs_q)               vs_cnt_d   = vinc(vs_cnt_q);
      if (act_cnt_q != '0)       vact_cnt_d = vinc(vact_cnt_q);
      if (act_cnt_q > max_act_q) max_act_d  = act_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fs_q       <= 1'b0;
      lcnt_q     <= '0;
      vs_cnt_q   <= '0;
      vact_cnt_q <= '0;
      max_act_q  <= '0;
    end else begin
      fs_q       <= frame_start;
      lcnt_q     <= lcnt_d;
      vs_cnt_q   <= vs_cnt_d;
      vact_cnt_q <= vact_cnt_d;
      max_act_q  <= max_act_d;
    end
  end

  // ---------------- lock FSM ----------------
  meas_t new_meas, meas_q;
  logic  frame_done_q, locked_q;

  assign new_meas = {last_h_total_q, last_hs_width_q, max_act_q,
                     lcnt_q, vs_cnt_q, vact_cnt_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SEARCH;
      meas_q       <= '0;
      frame_done_q <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (fs_q) begin
        case (state_q)
          SEARCH: state_q <= SYNC;
          SYNC: begin
            meas_q       <= new_meas;
            frame_done_q <= 1'b1;
            state_q      <= MEASURE;
          end
          MEASURE: begin
            meas_q       <= new_meas;
            frame_done_q <= 1'b1;
            if (new_meas == meas_q) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end
          end
          LOCKED: begin
            meas_q       <= new_meas;
            frame_done_q <= 1'b1;
            if (new_meas != meas_q) begin
              state_q  <= MEASURE;
              locked_q <= 1'b0;
            end
          end
          default: state_q <= SEARCH;
        endcase
      end
    end
  end

  assign h_total    = meas_q.h_total;
  assign hs_width   = meas_q.hs_width;
  assign h_active   = meas_q.h_active;
  assign v_total    = meas_q.v_total;
  assign vs_width   = meas_q.vs_width;
  assign v_active   = meas_q.v_active;
  assign frame_done = frame_done_q;
  assign locked     = locked_q;

  // ---------------- grey-ramp checker ----------------
`ifdef VID_TIMING_RX_PATTERN_CHECK_EN
  logic [3*PW-1:0]   s1_rgb_q;
  logic [PW-1:0]     exp_q, cmp_val;
  logic              seeded_q, pixel_err_q, mismatch;
  logic [ERR_BITS-1:0] err_cnt_q;

  // The seed pixel compares against its own blue component.
  assign cmp_val  = seeded_q ? exp_q : s1_rgb_q[PW-1:0];
  assign mismatch = locked_q & s1_vld_q & (s1_rgb_q != {cmp_val, cmp_val, cmp_val});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_rgb_q    <= '0;
      exp_q       <= '0;
      seeded_q    <= 1'b0;
      pixel_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      s1_rgb_q    <= rgb;
      pixel_err_q <= mismatch;
      if (mismatch && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + ERR_BITS'(1);
      if (!locked_q) begin
        seeded_q <= 1'b0;
      end else if (s1_vld_q) begin
        seeded_q <= 1'b1;
        exp_q    <= cmp_val + PW'(1);
      end
    end
  end

  assign pixel_err = pixel_err_q;
  assign err_cnt   = err_cnt_q;
`else
  logic unused_rgb;
  assign unused_rgb = ^rgb;
  assign pixel_err  = 1'b0;
  assign err_cnt    = '0;
`endif

endmodule

// File: tb/tb_vid_timing_rx.sv
// Bench for vid_timing_rx: table-driven frame sequences, reset/pattern corner cases,
// and randomized frame timings checked against a frame-level reference model.

module tb_vid_timing_rx;
  localparam int PW = 8;

`ifdef VID_TIMING_RX_PATTERN_CHECK_EN
  localparam int PAT = 1;
`else
  localparam int PAT = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hs = 1'b0, vs = 1'b0, vld = 1'b0;
  logic [3*PW-1:0] rgb = '0;

  logic [11:0] h_total, hs_width, h_active, v_total, vs_width, v_active;
  logic        frame_done, locked, pixel_err;
  logic [15:0] err_cnt;

  logic [3:0]  h_total4, hs_width4, h_active4;
  logic [11:0] v_total4, vs_width4, v_active4;
  logic        frame_done4, locked4, pixel_err4;
  logic [15:0] err_cnt4;

  vid_timing_rx #(.PW(PW), .H_BITS(12), .V_BITS(12), .ERR_BITS(16)) dut (
    .clk(clk), .rst_n(rst_n), .hs(hs), .vs(vs), .vld(vld), .rgb(rgb),
    .h_total(h_total), .hs_width(hs_width), .h_active(h_active),
    .v_total(v_total), .vs_width(vs_width), .v_active(v_active),
    .frame_done(frame_done), .locked(locked), .pixel_err(pixel_err), .err_cnt(err_cnt));

  vid_timing_rx #(.PW(PW), .H_BITS(4), .V_BITS(12), .ERR_BITS(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .hs(hs), .vs(vs), .vld(vld), .rgb(rgb),
    .h_total(h_total4), .hs_width(hs_width4), .h_active(h_active4),
    .v_total(v_total4), .vs_width(vs_width4), .v_active(v_active4),
    .frame_done(frame_done4), .locked(locked4), .pixel_err(pixel_err4), .err_cnt(err_cnt4));

  always #5 clk = ~clk;

  typedef struct {int hlen, hsw, nlines, vsl, a0, a1, alen, flip;} fp_t;
  typedef struct {int ht, hsw, ha, vt, vsw, va, lk; longint cyc;} rec_t;
  typedef struct {fp_t p; rec_t e; rec_t e4;} vec_t;

  int     compared = 0, mismatched = 0;
  longint cyc = 0;
  int     pe_cnt = 0, pe4_cnt = 0;
  int unsigned ramp = 0;
  rec_t   q1[$], q4[$];
  longint vs_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic rec_t mk_rec(input int ht, hsw, ha, vt, vsw, va, lk, input longint c);
    rec_t r;
    r.ht = ht; r.hsw = hsw; r.ha = ha; r.vt = vt; r.vsw = vsw; r.va = va; r.lk = lk; r.cyc = c;
    return r;
  endfunction

  always @(negedge clk) begin
    if (frame_done)
      q1.push_back(mk_rec(int'(h_total), int'(hs_width), int'(h_active), int'(v_total),
                          int'(vs_width), int'(v_active), int'(locked), cyc));
    if (frame_done4)
      q4.push_back(mk_rec(int'(h_total4), int'(hs_width4), int'(h_active4), int'(v_total4),
                          int'(vs_width4), int'(v_active4), int'(locked4), cyc));
    if (pixel_err)  pe_cnt  <= pe_cnt + 1;
    if (pixel_err4) pe4_cnt <= pe4_cnt + 1;
  end

  task automatic chk(input string name, input longint got, input longint exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, ".h_total"},    h_total,    0);
    chk({tag, ".hs_width"},   hs_width,   0);
    chk({tag, ".h_active"},   h_active,   0);
    chk({tag, ".v_total"},    v_total,    0);
    chk({tag, ".vs_width"},   vs_width,   0);
    chk({tag, ".v_active"},   v_active,   0);
    chk({tag, ".frame_done"}, frame_done, 0);
    chk({tag, ".locked"},     locked,     0);
    chk({tag, ".pixel_err"},  pixel_err,  0);
    chk({tag, ".err_cnt"},    err_cnt,    0);
  endtask

  task automatic cmp_rec(input string tag, input int i, input rec_t g, input rec_t e);
    string n;
    n = $sformatf("%s[%0d]", tag, i);
    chk({n, ".h_total"},  g.ht,  e.ht);
    chk({n, ".hs_width"}, g.hsw, e.hsw);
    chk({n, ".h_active"}, g.ha,  e.ha);
    chk({n, ".v_total"},  g.vt,  e.vt);
    chk({n, ".vs_width"}, g.vsw, e.vsw);
    chk({n, ".v_active"}, g.va,  e.va);
    chk({n, ".locked"},   g.lk,  e.lk);
  endtask

  // Record i is produced by frame-start edge i+1 (the first edge after reset only arms).
  task automatic check_recs(input string tag, input rec_t exp[$], input rec_t exp4[$]);
    chk({tag, ".count"},  q1.size(), exp.size());
    chk({tag, ".count4"}, q4.size(), exp4.size());
    for (int i = 0; i < q1.size() && i < exp.size(); i++) begin
      cmp_rec(tag, i, q1[i], exp[i]);
      if (i + 1 < vs_cyc.size())
        chk($sformatf("%s[%0d].latency", tag, i), q1[i].cyc - vs_cyc[i+1], 3);
    end
    for (int i = 0; i < q4.size() && i < exp4.size(); i++)
      cmp_rec({tag, "_h4"}, i, q4[i], exp4[i]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; hs = 1'b0; vs = 1'b0; vld = 1'b0; rgb = '0;
    repeat (3) @(posedge clk);
    #1;
    q1.delete(); q4.delete(); vs_cyc.delete();
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Drives one frame; rst_line >= 0 pulses reset in the middle of that line.
  task automatic drive_frame(input fp_t p, input int rst_line);
    int pix;
    logic [PW-1:0] v;
    pix = 0;
    for (int l = 0; l < p.nlines; l++) begin
      for (int c = 0; c < p.hlen; c++) begin
        @(posedge clk); #1;
        hs  = (c < p.hsw);
        vs  = (l < p.vsl);
        vld = (l >= p.a0 && l <= p.a1 && c >= p.hsw && c < p.hsw + p.alen);
        if (l == 0 && c == 0) vs_cyc.push_back(cyc);
        if (vld) begin
          v   = ramp[PW-1:0];
          rgb = {v, v, v};
          if (pix == p.flip) rgb[0] = ~rgb[0];
          ramp++;
          pix++;
        end else begin
          rgb = (3*PW)'($urandom);
        end
        if (l == rst_line && c == 8) begin
          rst_n = 1'b0;
          #2;
          chk_zero_outputs("async_reset");
          q1.delete(); q4.delete(); vs_cyc.delete();
        end
        if (l == rst_line && c == 12) rst_n = 1'b1;
      end
    end
  endtask

  task automatic close_stream();
    @(posedge clk); #1;
    hs = 1'b1; vs = 1'b1; vld = 1'b0;
    vs_cyc.push_back(cyc);
    repeat (3) @(posedge clk);
    #1;
    hs = 1'b0; vs = 1'b0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  // Frame-level reference: what one frame of these parameters must measure as.
  function automatic rec_t model(input fp_t p, input int hmax);
    rec_t r;
    bit act;
    act   = (p.a1 >= p.a0);
    r.ht  = (p.hlen > hmax) ? hmax : p.hlen;
    r.hsw = (p.hsw  > hmax) ? hmax : p.hsw;
    r.ha  = act ? ((p.alen > hmax) ? hmax : p.alen) : 0;
    r.vt  = p.nlines;
    r.vsw = p.vsl;
    r.va  = act ? (p.a1 - p.a0 + 1) : 0;
    r.lk  = 0;
    r.cyc = 0;
    return r;
  endfunction

  function automatic bit same(input rec_t a, input rec_t b);
    return a.ht == b.ht && a.hsw == b.hsw && a.ha == b.ha &&
           a.vt == b.vt && a.vsw == b.vsw && a.va == b.va;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vt[8];
    fp_t  base, wide, alt;
    rec_t ex[$], ex4[$];
    fp_t  fr[$];
    int   pe0, pe40;

    base = '{20, 4, 8, 2, 2, 5, 10, -1};
    wide = '{22, 4, 8, 2, 2, 5, 10, -1};
    alt  = '{20, 5, 9, 3, 1, 6, 12, -1};
    vt[0] = '{base, '{20,4,10,8,2,4,0,0}, '{15,4,10,8,2,4,0,0}};
    vt[1] = '{base, '{20,4,10,8,2,4,1,0}, '{15,4,10,8,2,4,1,0}};
    vt[2] = '{base, '{20,4,10,8,2,4,1,0}, '{15,4,10,8,2,4,1,0}};
    vt[3] = '{wide, '{22,4,10,8,2,4,0,0}, '{15,4,10,8,2,4,1,0}};
    vt[4] = '{base, '{20,4,10,8,2,4,0,0}, '{15,4,10,8,2,4,1,0}};
    vt[5] = '{base, '{20,4,10,8,2,4,1,0}, '{15,4,10,8,2,4,1,0}};
    vt[6] = '{base, '{20,4,10,8,2,4,1,0}, '{15,4,10,8,2,4,1,0}};
    vt[7] = '{alt,  '{20,5,12,9,3,6,0,0}, '{15,5,12,9,3,6,0,0}};

    // Table section: nominal lock, one long-line frame, relock, ramp wrap while locked.
    do_reset();
    chk_zero_outputs("reset");
    pe0 = pe_cnt; pe40 = pe4_cnt;
    for (int i = 0; i < 8; i++) drive_frame(vt[i].p, -1);
    close_stream();
    ex.delete(); ex4.delete();
    for (int i = 0; i < 8; i++) begin
      ex.push_back(vt[i].e);
      ex4.push_back(vt[i].e4);
    end
    check_recs("table", ex, ex4);
    chk("table.pixel_err_pulses", pe_cnt - pe0, 0);
    chk("table.err_cnt", err_cnt, 0);

    // One corrupted pixel while locked, then a timing change drops lock.
    do_reset();
    pe0 = pe_cnt; pe40 = pe4_cnt;
    for (int i = 0; i < 5; i++) begin
      fp_t p;
      p = base;
      if (i == 3) p.flip = 15;
      drive_frame(p, -1);
    end
    close_stream();
    chk("flip.pixel_err_pulses", pe_cnt - pe0, PAT);
    chk("flip.err_cnt", err_cnt, PAT);
    chk("flip.pixel_err_pulses_h4", pe4_cnt - pe40, PAT);
    chk("flip.err_cnt_h4", err_cnt4, PAT);
    drive_frame(wide, -1);
    drive_frame(base, -1);
    close_stream();
    chk("flip.err_cnt_hold", err_cnt, PAT);
    chk("flip.pixel_err_after", pe_cnt - pe0, PAT);

    // Reset mid-frame while locked.
    do_reset();
    for (int i = 0; i < 3; i++) drive_frame(base, -1);
    chk("rst.locked_before", locked, 1);
    drive_frame(base, 4);
    for (int i = 0; i < 3; i++) drive_frame(base, -1);
    close_stream();
    ex.delete(); ex4.delete();
    ex.push_back(vt[0].e);  ex.push_back(vt[1].e);  ex.push_back(vt[2].e);
    ex4.push_back(vt[0].e4); ex4.push_back(vt[1].e4); ex4.push_back(vt[2].e4);
    check_recs("rst", ex, ex4);
    chk("rst.err_cnt", err_cnt, 0);

    // Randomized frame timings, each set repeated 1..3 times to exercise lock/unlock.
    do_reset();
    pe0 = pe_cnt; pe40 = pe4_cnt;
    fr.delete();
    for (int s = 0; s < 12; s++) begin
      fp_t p;
      int  rep;
      p.hsw    = int'($urandom_range(1, 6));
      p.alen   = int'($urandom_range(1, 14));
      p.hlen   = int'($urandom_range(p.hsw + p.alen + 1, 40));
      p.nlines = int'($urandom_range(4, 9));
      p.vsl    = int'($urandom_range(1, 3));
      if ($urandom_range(0, 4) == 0) begin
        p.a0 = 1; p.a1 = 0;
      end else begin
        p.a0 = int'($urandom_range(0, p.nlines - 1));
        p.a1 = int'($urandom_range(p.a0, p.nlines - 1));
      end
      p.flip = -1;
      rep = int'($urandom_range(1, 3));
      for (int r = 0; r < rep; r++) fr.push_back(p);
    end
    foreach (fr[k]) drive_frame(fr[k], -1);
    close_stream();
    ex.delete(); ex4.delete();
    foreach (fr[k]) begin
      rec_t e, e4;
      e  = model(fr[k], 4095);
      e4 = model(fr[k], 15);
      if (k > 0) begin
        e.lk  = same(e,  ex[k-1])  ? 1 : 0;
        e4.lk = same(e4, ex4[k-1]) ? 1 : 0;
      end
      ex.push_back(e);
      ex4.push_back(e4);
    end
    check_recs("rand", ex, ex4);
    chk("rand.pixel_err_pulses", pe_cnt - pe0, 0);
    chk("rand.pixel_err_pulses_h4", pe4_cnt - pe40, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
